// File: rtl/axibram_read_if.sv
// AXI3 read channels (AR and R) between the GP master
// and the BRAM read slave.
interface axibram_read_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [11:0] arid;
  logic [3:0]  arlen;
  logic [1:0]  arsize;
  logic [1:0]  arburst;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [11:0] rid;
  logic        rlast;
  logic [1:0]  rresp;

  modport master (
    output araddr, arvalid, arid, arlen,
    output arsize, arburst, rready,
    input  arready, rdata, rvalid, rid,
    input  rlast, rresp
  );

  modport slave (
    input  araddr, arvalid, arid, arlen,
    input  arsize, arburst, rready,
    output arready, rdata, rvalid, rid,
    output rlast, rresp
  );
endinterface

// File: rtl/axibram_read_slave.sv
// AXI3 read slave: queues AR bursts, issues BRAM word reads
// with a two-cycle read latency and returns beats on R.
module axibram_read_slave #(
  parameter int ADDRESS_BITS = 10
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  axibram_read_if.slave           bus,
  output logic [ADDRESS_BITS-1:0] pre_araddr,
  output logic                    start_burst,
  input  logic                    dev_ready,
  output logic                    bram_rclk,
  output logic [ADDRESS_BITS-1:0] bram_raddr,
  output logic                    bram_ren,
  output logic                    bram_regen,
  input  logic [31:0]             bram_rdata
);
  localparam int AW = ADDRESS_BITS;
  localparam logic [AW-1:0] A_ONE = AW'(1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;
  state_t state, state_n;

  logic [11:0]   q_id    [4];
  logic [1:0]    q_burst [4];
  logic [3:0]    q_len   [4];
  logic [AW-1:0] q_addr  [4];
  logic [1:0]    q_wp, q_rp;
  logic [2:0]    q_cnt;
  logic          q_push, q_nempty;

  logic          dev_ready_r;
  logic [AW-1:0] raddr, raddr_n;
  logic [3:0]    left, len;
  logic [1:0]    burst;
  logic [11:0]   id;
  logic          busy, credit, issue, last_issue;
  logic [3:0]    inflight;

  logic          ren_d1, ren_d2;
  logic          tag1_last, tag2_last;
  logic [11:0]   tag1_id, tag2_id;

  logic [31:0]   o_data [4];
  logic [11:0]   o_id   [4];
  logic          o_last [4];
  logic [1:0]    o_wp, o_rp;
  logic [2:0]    o_cnt;
  logic          o_pop, rvalid_w;
  logic          unused;

  assign unused = ^{bus.arsize, bus.araddr[31:AW+2],
                    bus.araddr[1:0]};

  assign bram_rclk   = aclk;
  assign bus.arready = aresetn && (q_cnt < 3'd2);
  assign q_push      = bus.arvalid && bus.arready;
  assign q_nempty    = q_cnt != 3'd0;
  assign pre_araddr  = q_nempty ? q_addr[q_rp] : '0;

  assign busy       = state == S_BUSY;
  assign inflight   = 4'(o_cnt) + 4'(ren_d1) + 4'(ren_d2);
  assign credit     = inflight < 4'd4;
  assign issue      = aresetn && busy && dev_ready_r && credit;
  assign last_issue = issue && (left == 4'd0);
  assign start_burst = aresetn && q_nempty && dev_ready_r &&
                       (!busy || last_issue);

  assign bram_ren   = issue;
  assign bram_raddr = aresetn ? raddr : '0;
  assign bram_regen = aresetn && ren_d1;

  assign rvalid_w   = aresetn && (o_cnt != 3'd0);
  assign o_pop      = rvalid_w && bus.rready;
  assign bus.rvalid = rvalid_w;
  assign bus.rdata  = rvalid_w ? o_data[o_rp] : '0;
  assign bus.rid    = rvalid_w ? o_id[o_rp] : '0;
  assign bus.rlast  = rvalid_w && o_last[o_rp];
  assign bus.rresp  = 2'b00;

  // Address queue storage, written on AR handshake.
  always_ff @(posedge aclk) begin
    if (q_push) begin
      q_id[q_wp]    <= bus.arid;
      q_burst[q_wp] <= bus.arburst;
      q_len[q_wp]   <= bus.arlen;
      q_addr[q_wp]  <= bus.araddr[AW+1:2];
    end
  end

  // Address queue pointers; a burst start pops the head.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      q_wp  <= '0;
      q_rp  <= '0;
      q_cnt <= '0;
    end else begin
      if (q_push) q_wp <= q_wp + 2'd1;
      if (start_burst) q_rp <= q_rp + 2'd1;
      q_cnt <= q_cnt + 3'(q_push) - 3'(start_burst);
    end
  end

  // Registered device ready from the external decode mux.
  always_ff @(posedge aclk) begin
    if (!aresetn) dev_ready_r <= 1'b0;
    else          dev_ready_r <= dev_ready;
  end

  // Burst state register.
  always_ff @(posedge aclk) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_n;
  end

  // Next state: a start wins over the final issue.
  always_comb begin
    state_n = state;
    if (start_burst)     state_n = S_BUSY;
    else if (last_issue) state_n = S_IDLE;
  end

  // Next word address for FIXED, INCR and WRAP bursts.
  always_comb begin
    raddr_n = raddr;
    unique case (1'b1)
      burst == 2'b01: raddr_n = raddr + A_ONE;
      burst == 2'b10: raddr_n = {raddr[AW-1:4],
        (raddr[3:0] & ~len) | ((raddr[3:0] + 4'd1) & len)};
      default:        raddr_n = raddr;
    endcase
  end

  // Burst registers: load from queue head or step per issue.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      raddr <= '0;
      left  <= '0;
      len   <= '0;
      burst <= '0;
      id    <= '0;
    end else if (start_burst) begin
      raddr <= q_addr[q_rp];
      left  <= q_len[q_rp];
      len   <= q_len[q_rp];
      burst <= q_burst[q_rp];
      id    <= q_id[q_rp];
    end else if (issue) begin
      raddr <= raddr_n;
      left  <= left - 4'd1;
    end
  end

  // Tag pipeline tracking the BRAM read latency.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ren_d1    <= 1'b0;
      ren_d2    <= 1'b0;
      tag1_id   <= '0;
      tag2_id   <= '0;
      tag1_last <= 1'b0;
      tag2_last <= 1'b0;
    end else begin
      ren_d1    <= issue;
      ren_d2    <= ren_d1;
      tag1_id   <= id;
      tag1_last <= left == 4'd0;
      tag2_id   <= tag1_id;
      tag2_last <= tag1_last;
    end
  end

  // Output FIFO storage, filled when BRAM data is valid.
  always_ff @(posedge aclk) begin
    if (ren_d2) begin
      o_data[o_wp] <= bram_rdata;
      o_id[o_wp]   <= tag2_id;
      o_last[o_wp] <= tag2_last;
    end
  end

  // Output FIFO pointers; credit bounds occupancy to 4.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      o_wp  <= '0;
      o_rp  <= '0;
      o_cnt <= '0;
    end else begin
      if (ren_d2) o_wp <= o_wp + 2'd1;
      if (o_pop)  o_rp <= o_rp + 2'd1;
      o_cnt <= o_cnt + 3'(ren_d2) - 3'(o_pop);
    end
  end
endmodule

// File: tb/tb_axibram_read_slave.sv
// Bench for axibram_read_slave: directed bursts plus random
// traffic scored against a burst-address reference model.
module tb_axibram_read_slave;
  localparam int AW = 10;

  typedef struct {
    logic [11:0] id;
    logic        last;
    logic [31:0] data;
  } beat_t;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [AW-1:0] pre_araddr;
  logic          start_burst;
  logic          dev_ready;
  logic          bram_rclk;
  logic [AW-1:0] bram_raddr;
  logic          bram_ren;
  logic          bram_regen;
  logic [31:0]   bram_rdata;

  axibram_read_if bus ();

  axibram_read_slave #(.ADDRESS_BITS(AW)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .bus         (bus),
    .pre_araddr  (pre_araddr),
    .start_burst (start_burst),
    .dev_ready   (dev_ready),
    .bram_rclk   (bram_rclk),
    .bram_raddr  (bram_raddr),
    .bram_ren    (bram_ren),
    .bram_regen  (bram_regen),
    .bram_rdata  (bram_rdata)
  );

  always #5 aclk = ~aclk;

  logic [31:0]   mem [1024];
  logic [AW-1:0] lat_addr;
  logic [31:0]   dout;

  always @(posedge bram_rclk) begin
    if (bram_ren)   lat_addr <= bram_raddr;
    if (bram_regen) dout <= mem[lat_addr];
  end
  assign bram_rdata = dout;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int issued, popped, max_out;
  int first_sb, first_ren, first_rv;
  logic [AW-1:0] first_ren_addr;
  int ren_cnt, run, max_run, sb_ren, rx;
  bit hs, rnd;

  logic [AW-1:0] exp_addr [$];
  logic [AW-1:0] exp_head [$];
  beat_t         exp_beat [$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Expected addresses/beats of one burst from plain arithmetic.
  task automatic model_push(input logic [11:0] id,
                            input logic [31:0] addr,
                            input logic [3:0] len,
                            input logic [1:0] bt);
    int w, n, base;
    beat_t b;
    w = int'(addr[11:2]);
    n = int'(len) + 1;
    exp_head.push_back(AW'(w));
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(AW'(w));
      b.id = id;
      b.last = (i == n - 1);
      b.data = mem[w];
      exp_beat.push_back(b);
      if (bt == 2'b01) begin
        w = (w + 1) % 1024;
      end else if (bt == 2'b10) begin
        base = w - (w % n);
        w = base + ((w % n) + 1) % n;
      end
    end
  endtask

  // One clock: observe at negedge, advance past posedge.
  task automatic cycle();
    bit rst_edge;
    beat_t e;
    @(negedge aclk);
    rst_edge = !aresetn;
    hs = 1'b0;
    if (!aresetn) begin
      chk("arready_in_reset", 32'(bus.arready), 0);
    end else begin
      if (bus.arvalid && bus.arready) begin
        hs = 1'b1;
        model_push(bus.arid, bus.araddr, bus.arlen,
                   bus.arburst);
      end
      if (start_burst) begin
        if (first_sb < 0) first_sb = cyc;
        if (bram_ren) sb_ren++;
        chk("start_has_burst", 32'(exp_head.size() > 0), 1);
        if (exp_head.size() > 0)
          chk("pre_araddr", 32'(pre_araddr),
              32'(exp_head.pop_front()));
      end
      if (bram_ren) begin
        issued++;
        ren_cnt++;
        if (first_ren < 0) begin
          first_ren = cyc;
          first_ren_addr = bram_raddr;
        end
        if (issued - popped > max_out)
          max_out = issued - popped;
        chk("outstanding_le4", 32'(issued - popped <= 4), 1);
        chk("ren_has_addr", 32'(exp_addr.size() > 0), 1);
        if (exp_addr.size() > 0)
          chk("bram_raddr", 32'(bram_raddr),
              32'(exp_addr.pop_front()));
      end
      if (bus.rvalid) begin
        run++;
        if (run > max_run) max_run = run;
        if (first_rv < 0) first_rv = cyc;
      end else begin
        run = 0;
      end
      if (bus.rvalid && bus.rready) begin
        popped++;
        rx++;
        chk("beat_expected", 32'(exp_beat.size() > 0), 1);
        if (exp_beat.size() > 0) begin
          e = exp_beat.pop_front();
          chk("rdata", bus.rdata, e.data);
          chk("rid", 32'(bus.rid), 32'(e.id));
          chk("rlast", 32'(bus.rlast), 32'(e.last));
          chk("rresp", 32'(bus.rresp), 0);
        end
      end
    end
    @(posedge aclk);
    #1;
    cyc++;
    if (rst_edge) begin
      exp_addr.delete();
      exp_head.delete();
      exp_beat.delete();
      issued = 0;
      popped = 0;
    end
    if (rnd) begin
      bus.rready = $urandom_range(0, 3) != 0;
      dev_ready  = $urandom_range(0, 7) != 0;
    end
  endtask

  task automatic send_ar(input logic [11:0] id,
                         input logic [31:0] addr,
                         input logic [3:0] len,
                         input logic [1:0] bt);
    bus.arid    = id;
    bus.araddr  = addr;
    bus.arlen   = len;
    bus.arburst = bt;
    bus.arsize  = 2'b10;
    bus.arvalid = 1'b1;
    hs = 1'b0;
    for (int i = 0; i < 200 && !hs; i++) cycle();
    bus.arvalid = 1'b0;
    chk("ar_handshake", 32'(hs), 1);
  endtask

  task automatic drain();
    bus.rready = 1'b1;
    dev_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (exp_beat.size() == 0 && !bus.rvalid) break;
      cycle();
    end
    repeat (4) cycle();
    chk("drain_left", 32'(exp_beat.size()), 0);
  endtask

  task automatic check_reset();
    chk("rst_rvalid", 32'(bus.rvalid), 0);
    chk("rst_arready", 32'(bus.arready), 0);
    chk("rst_start", 32'(start_burst), 0);
    chk("rst_ren", 32'(bram_ren), 0);
    chk("rst_regen", 32'(bram_regen), 0);
    chk("rst_rlast", 32'(bus.rlast), 0);
    chk("rst_rid", 32'(bus.rid), 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_raddr", 32'(bram_raddr), 0);
  endtask

  task automatic clr_marks();
    first_sb = -1;
    first_ren = -1;
    first_rv = -1;
    sb_ren = 0;
    max_run = 0;
    max_out = 0;
    ren_cnt = 0;
    rx = 0;
  endtask

  initial begin
    int t0;
    logic [1:0] bt;
    logic [3:0] ln;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    rnd = 1'b0;
    issued = 0;
    popped = 0;
    run = 0;
    clr_marks();
    aresetn = 1'b0;
    dev_ready = 1'b1;
    bus.rready = 1'b1;
    bus.arvalid = 1'b0;
    bus.araddr = '0;
    bus.arid = '0;
    bus.arlen = '0;
    bus.arburst = '0;
    bus.arsize = 2'b10;
    repeat (3) cycle();
    check_reset();
    aresetn = 1'b1;
    repeat (3) cycle();

    // single read
    clr_marks();
    send_ar(12'h05A, 32'h10, 4'd0, 2'b01);
    t0 = cyc - 1;
    drain();
    chk("single_sb_lat", 32'(first_sb - t0), 1);
    chk("single_ren_lat", 32'(first_ren - t0), 2);
    chk("single_rv_lat", 32'(first_rv - t0), 5);
    chk("single_addr", 32'(first_ren_addr), 4);
    chk("single_beats", 32'(rx), 1);

    // INCR 16 across the address wrap, rready toggling
    clr_marks();
    send_ar(12'h111, 32'h3F8 << 2, 4'd15, 2'b01);
    for (int i = 0; i < 60; i++) begin
      bus.rready = (i % 2) == 0;
      cycle();
    end
    drain();
    chk("incr16_beats", 32'(rx), 16);
    chk("incr16_max_out", 32'(max_out), 4);

    // WRAP 4 at word 6
    clr_marks();
    send_ar(12'h222, 32'h06 << 2, 4'd3, 2'b10);
    drain();
    chk("wrap_beats", 32'(rx), 4);

    // back-to-back bursts
    clr_marks();
    send_ar(12'h001, 32'h40, 4'd3, 2'b01);
    send_ar(12'h002, 32'h80, 4'd1, 2'b01);
    drain();
    chk("b2b_contig", 32'(max_run), 6);
    chk("b2b_sb_with_ren", 32'(sb_ren), 1);

    // dev_ready stall with queue filling
    clr_marks();
    send_ar(12'h003, 32'h100 << 2, 4'd7, 2'b01);
    repeat (3) cycle();
    dev_ready = 1'b0;
    cycle();
    ren_cnt = 0;
    bus.arid = 12'h004;
    bus.araddr = 32'h200 << 2;
    bus.arlen = 4'd1;
    bus.arburst = 2'b01;
    bus.arvalid = 1'b1;
    cycle();
    chk("stall_ar_a", 32'(hs), 1);
    bus.arid = 12'h005;
    bus.araddr = 32'h300 << 2;
    bus.arlen = 4'd0;
    cycle();
    chk("stall_ar_b", 32'(hs), 1);
    bus.arid = 12'h006;
    #1;
    chk("arready_full", 32'(bus.arready), 0);
    cycle();
    chk("stall_ar_c", 32'(hs), 0);
    bus.arvalid = 1'b0;
    cycle();
    dev_ready = 1'b1;
    cycle();
    chk("stall_no_ren", 32'(ren_cnt), 0);
    drain();
    chk("stall_beats", 32'(rx), 11);

    // reset during beat 3 of an 8-beat burst
    clr_marks();
    send_ar(12'h007, 32'h40, 4'd7, 2'b01);
    for (int i = 0; i < 60 && rx < 2; i++) cycle();
    chk("pre_reset_beats", 32'(rx), 2);
    aresetn = 1'b0;
    cycle();
    check_reset();
    aresetn = 1'b1;
    repeat (2) cycle();
    clr_marks();
    send_ar(12'h008, 32'h80, 4'd0, 2'b00);
    drain();
    chk("post_reset_beats", 32'(rx), 1);

    // random traffic
    clr_marks();
    rnd = 1'b1;
    for (int k = 0; k < 25; k++) begin
      bt = 2'($urandom_range(0, 3));
      ln = 4'($urandom_range(0, 15));
      if (bt == 2'b10) ln = 4'((1 << $urandom_range(1, 4)) - 1);
      send_ar(12'($urandom), $urandom, ln, bt);
      repeat ($urandom_range(0, 3)) cycle();
    end
    rnd = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axibram_read_slave.md
# axibram_read_slave

AXI3 read-side slave for the PS Master GP interface: accepts read-address bursts, issues word reads to an external block RAM (or other register-latency read source), and returns data on the R channel with correct RID, RLAST and RRESP. Counterpart of the BRAM write slave on the same GP port and shares its external address/decode conventions (pre-address, start-of-burst strobe, multiplexed device-ready). Sits between the PS GP master and the BRAM/register read mux.

## Interface
- ADDRESS_BITS, 10, word address width presented to memory (araddr[ADDRESS_BITS+1:2])
- aclk  input  1  clock, buffered; all logic on rising edge
- aresetn  input  1  reset, synchronous, active low
- araddr  input  32  read byte address; bits [1:0] ignored
- arvalid  input  1  address valid
- arready  output  1  address accepted
- arid  input  12  transaction ID
- arlen  input  4  beats-1
- arsize  input  2  ignored (always 32-bit)
- arburst  input  2  00 FIXED, 01 INCR, 10 WRAP, 11 treated as FIXED
- rdata  output  32  read data
- rvalid  output  1  data valid
- rready  input  1  master ready
- rid  output  12  ID of returning beat
- rlast  output  1  last beat of burst
- rresp  output  2  always 2'b00
- pre_araddr  output  ADDRESS_BITS  head-of-queue word address, for external decode
- start_burst  output  1  one-cycle strobe, burst at queue head starts
- dev_ready  input  1  external ready, muxed per decoded pre_araddr
- bram_rclk  output  1  = aclk
- bram_raddr  output  ADDRESS_BITS  read word address
- bram_ren  output  1  read enable (address latch)
- bram_regen  output  1  output-register enable, = bram_ren delayed 1
- bram_rdata  input  32  data, valid 2 cycles after bram_ren

## Operation
- Address queue: 4 entries {arid, arburst, arlen, araddr word}; push on arvalid&&arready; arready = aresetn && (count<2). Pop on start_burst.
- dev_ready_r: dev_ready registered each cycle; gates start and issue.
- Burst regs: busy, raddr, left[3:0], len[3:0], burst[1:0], id[11:0].
- issue = busy && dev_ready_r && credit; credit = (out_count + ren_d1 + ren_d2) < 4.
- start_burst = q_nempty && dev_ready_r && (!busy || (issue && left==0)); loads regs from queue head; busy set. Start and last issue of previous burst may coincide.
- busy clears when issue && left==0 and no start same cycle.
- On issue: bram_ren=1 at bram_raddr=raddr; left-=1; raddr <= next: FIXED/11 hold; INCR +1 (wraps modulo 2^ADDRESS_BITS); WRAP low 4 bits = (raddr&~len)|((raddr+1)&len), upper bits held (len must be 1,3,7,15).
- Tag pipeline carries {id, left==0} alongside ren_d1, ren_d2; at ren_d2 cycle {id, last, bram_rdata} pushed into 4-entry output FIFO.
- R channel: rvalid = out FIFO nonempty; rdata/rid/rlast from head; pop on rvalid&&rready. Credit guarantees no overflow.

## Timing
- AR handshake in cycle T (dev_ready_r=1, idle): start_burst T+1, first bram_ren T+2, bram_regen T+3, data captured end of T+4, rvalid T+5.
- rready held high, dev_ready_r high: one beat/cycle sustained, no bubbles across back-to-back bursts.
- rready low: at most 4 beats outstanding; bram_ren stops when credit exhausted, resumes the cycle after a pop frees credit.
- dev_ready_r low: no start, no issue; in-flight beats still delivered.
- Reset (aresetn low at edge): queue, burst regs, pipeline, output FIFO cleared; during and after reset cycle arready=0 while low, rvalid=0, start_burst=0, bram_ren=0, bram_regen=0, rlast=0, rid=0, rdata=0, bram_raddr=0. Mid-burst reset abandons burst; no rlast issued.

## Test plan
- Single read araddr=0x10, arlen=0, INCR, arid=0x5A -> bram_raddr=4, rvalid at T+5, rlast=1, rid=0x5A, rresp=0.
- INCR arlen=15 from word 0x3F8 (ADDRESS_BITS=10), rready toggling 1/0 -> 16 beats words 0x3F8..0x3FF,0x000..0x007, rlast on 16th only, never >4 outstanding.
- WRAP arlen=3 at word 0x06 -> addresses 6,7,4,5; rlast on 4th.
- Two back-to-back bursts (arid 1 len 3, arid 2 len 1), rready=1 -> 6 contiguous rvalid cycles, rid 1,1,1,1,2,2; second start_burst coincides with last issue of first.
- dev_ready low for 5 cycles mid-burst -> bram_ren stalls, data/order intact; arready low when 2 addresses queued.
- aresetn low during beat 3 of arlen=7 -> next cycle rvalid=0, arready=0; after release new single read completes normally.
